// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit in front of a word-addressed DataMemory.
// Build option: LSU_MISALIGN_TRAP_EN drops misaligned word/half requests with a Misaligned pulse.
module load_store_unit #(
  parameter int MEM_ADDR_W = 6
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Req,
  output logic                  Ready,
  input  logic [2:0]            Op,
  input  logic [31:0]           Addr,
  input  logic [31:0]           StoreData,
  output logic [31:0]           LoadData,
  output logic                  LoadValid,
  output logic                  Misaligned,
  output logic [MEM_ADDR_W-1:0] MemAddress,
  output logic [31:0]           MemWriteData,
  output logic                  MemoryRead,
  output logic                  MemoryWrite,
  input  logic [31:0]           MemReadData
);

  typedef enum logic [2:0] {
    OP_LB  = 3'b000, OP_LH  = 3'b001, OP_LW = 3'b010, OP_LBU = 3'b011,
    OP_LHU = 3'b100, OP_SB  = 3'b101, OP_SH = 3'b110, OP_SW  = 3'b111
  } op_e;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RESP, S_MERGE, S_WR} state_e;

  state_e                state, state_nxt;
  op_e                   op_q;
  logic [1:0]            off_q;
  logic [31:0]           data_q;
  logic [MEM_ADDR_W-1:0] word_q;

  op_e        op_in;
  logic       accept, trap, is_word_in, is_half_in;
  logic [1:0] off_in;
  logic [31:0] load_ext, merged;
  logic       unused_addr;

  assign op_in       = op_e'(Op);
  assign accept      = Req && Ready;
  assign is_word_in  = op_in inside {OP_LW, OP_SW};
  assign is_half_in  = op_in inside {OP_LH, OP_LHU, OP_SH};
  assign unused_addr = ^Addr[31:MEM_ADDR_W+2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign off_in = Addr[1:0];
  assign trap   = accept && ((is_word_in && Addr[1:0] != 2'b00) || (is_half_in && Addr[0]));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) Misaligned <= 1'b0;
    else       Misaligned <= trap;
  end
`else
  // Without the trap the offset is silently aligned to the access size.
  assign off_in     = is_word_in ? 2'b00 : (is_half_in ? {Addr[1], 1'b0} : Addr[1:0]);
  assign trap       = 1'b0;
  assign Misaligned = 1'b0;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      op_q      <= OP_LB;
      off_q     <= '0;
      data_q    <= '0;
      word_q    <= '0;
      LoadData  <= '0;
      LoadValid <= 1'b0;
    end else begin
      state     <= state_nxt;
      LoadValid <= (state == S_RESP);
      if (state == S_RESP) LoadData <= load_ext;
      if (accept) begin
        op_q   <= op_in;
        off_q  <= off_in;
        data_q <= StoreData;
        word_q <= Addr[MEM_ADDR_W+1:2];
      end
    end
  end

  // Big-endian lanes: offset 0 is the most significant byte/half.
  always_comb begin
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    lane_b = '0;
    case (off_q)
      2'd0: lane_b = MemReadData[31:24];
      2'd1: lane_b = MemReadData[23:16];
      2'd2: lane_b = MemReadData[15:8];
      default: lane_b = MemReadData[7:0];
    endcase
    lane_h = off_q[1] ? MemReadData[15:0] : MemReadData[31:16];
    case (op_q)
      OP_LB:   load_ext = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  load_ext = {24'h0, lane_b};
      OP_LH:   load_ext = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  load_ext = {16'h0, lane_h};
      default: load_ext = MemReadData;
    endcase
  end

  always_comb begin
    merged = MemReadData;
    if (op_q == OP_SH) begin
      if (off_q[1]) merged[15:0]  = data_q[15:0];
      else          merged[31:16] = data_q[15:0];
    end else begin
      case (off_q)
        2'd0: merged[31:24] = data_q[7:0];
        2'd1: merged[23:16] = data_q[7:0];
        2'd2: merged[15:8]  = data_q[7:0];
        default: merged[7:0] = data_q[7:0];
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    Ready        = 1'b0;
    MemoryRead   = 1'b0;
    MemoryWrite  = 1'b0;
    MemWriteData = '0;
    MemAddress   = word_q;
    case (state)
      S_IDLE: begin
        Ready = 1'b1;
        if (accept && !trap) state_nxt = (op_in == OP_SW) ? S_WR : S_RD;
      end
      S_RD: begin
        MemoryRead = 1'b1;
        state_nxt  = (op_q inside {OP_SB, OP_SH}) ? S_MERGE : S_RESP;
      end
      S_RESP: state_nxt = S_IDLE;
      S_MERGE: begin
        MemoryWrite  = 1'b1;
        MemWriteData = merged;
        state_nxt    = S_IDLE;
      end
      S_WR: begin
        MemoryWrite  = 1'b1;
        MemWriteData = data_q;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural DataMemory (read at posedge, write at negedge).
module tb_load_store_unit;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b011,
                         LHU = 3'b100, SB = 3'b101, SH = 3'b110, SW = 3'b111;

  logic        Clock = 1'b0, Reset = 1'b0, Req = 1'b0;
  logic [2:0]  Op = '0;
  logic [31:0] Addr = '0, StoreData = '0;
  logic        Ready, LoadValid, Misaligned, MemoryRead, MemoryWrite;
  logic [31:0] LoadData, MemWriteData;
  logic [5:0]  MemAddress;
  logic [31:0] MemReadData = '0;
  logic [31:0] mem [64];

  int vectors = 0, miscompares = 0;

  load_store_unit #(.MEM_ADDR_W(6)) dut (
    .Clock(Clock), .Reset(Reset), .Req(Req), .Ready(Ready), .Op(Op), .Addr(Addr),
    .StoreData(StoreData), .LoadData(LoadData), .LoadValid(LoadValid),
    .Misaligned(Misaligned), .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemoryRead(MemoryRead), .MemoryWrite(MemoryWrite), .MemReadData(MemReadData)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) if (MemoryRead) MemReadData <= mem[MemAddress];
  always @(negedge Clock) if (MemoryWrite) mem[MemAddress] <= MemWriteData;

  task automatic cyc();
    @(posedge Clock);
    #3;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
    Op = op; Addr = addr; StoreData = data; Req = 1'b1;
  endtask

  task automatic store_word(input logic [31:0] addr, input logic [31:0] data);
    logic [5:0] w;
    w = addr[7:2];
    start(SW, addr, data);
    cyc(); Req = 1'b0;
    chk("sw_wr_en", {31'b0, MemoryWrite}, 32'd1);
    chk("sw_rd_en", {31'b0, MemoryRead}, 32'd0);
    chk("sw_addr", {26'b0, MemAddress}, {26'b0, w});
    chk("sw_wdata", MemWriteData, data);
    chk("sw_busy", {31'b0, Ready}, 32'd0);
    cyc();
    chk("sw_idle_wr", {31'b0, MemoryWrite}, 32'd0);
    chk("sw_ready", {31'b0, Ready}, 32'd1);
    chk("sw_mem", mem[w], data);
  endtask

  task automatic load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] exp);
    start(op, addr, 32'h0);
    cyc(); Req = 1'b0;
    chk("ld_rd_en", {31'b0, MemoryRead}, 32'd1);
    chk("ld_rd_nowr", {31'b0, MemoryWrite}, 32'd0);
    chk("ld_addr", {26'b0, MemAddress}, {26'b0, addr[7:2]});
    cyc();
    chk("ld_resp_rd", {31'b0, MemoryRead}, 32'd0);
    chk("ld_resp_valid", {31'b0, LoadValid}, 32'd0);
    cyc();
    chk("ld_valid", {31'b0, LoadValid}, 32'd1);
    chk("ld_data", LoadData, exp);
    chk("ld_misal", {31'b0, Misaligned}, 32'd0);
    chk("ld_ready", {31'b0, Ready}, 32'd1);
    cyc();
    chk("ld_valid_pulse", {31'b0, LoadValid}, 32'd0);
    chk("ld_data_hold", LoadData, exp);
  endtask

  task automatic sub_store(input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] exp);
    start(op, addr, data);
    cyc(); Req = 1'b0;
    chk("ss_rd_en", {31'b0, MemoryRead}, 32'd1);
    chk("ss_rd_nowr", {31'b0, MemoryWrite}, 32'd0);
    cyc();
    chk("ss_wr_en", {31'b0, MemoryWrite}, 32'd1);
    chk("ss_wr_nord", {31'b0, MemoryRead}, 32'd0);
    chk("ss_wdata", MemWriteData, exp);
    cyc();
    chk("ss_mem", mem[addr[7:2]], exp);
    chk("ss_idle_wr", {31'b0, MemoryWrite}, 32'd0);
  endtask

  initial begin
    #1 Reset = 1'b1;
    #2;
    chk("rst_ready", {31'b0, Ready}, 32'd1);
    chk("rst_ldata", LoadData, 32'h0);
    chk("rst_lvalid", {31'b0, LoadValid}, 32'd0);
    chk("rst_misal", {31'b0, Misaligned}, 32'd0);
    chk("rst_rd", {31'b0, MemoryRead}, 32'd0);
    chk("rst_wr", {31'b0, MemoryWrite}, 32'd0);
    chk("rst_maddr", {26'b0, MemAddress}, 32'h0);
    chk("rst_wdata", MemWriteData, 32'h0);
    cyc(); cyc();
    Reset = 1'b0;
    cyc();

    // 1: word store and load
    store_word(32'h10, 32'hDEADBEEF);
    load(LW, 32'h10, 32'hDEADBEEF);

    // 2: sub-word read-modify-write
    sub_store(SB, 32'h11, 32'h000000AA, 32'hDEAABEEF);
    sub_store(SH, 32'h12, 32'h00001234, 32'hDEAA1234);

    // 3: lane extraction and extension
    store_word(32'h10, 32'hDEADBEEF);
    load(LB,  32'h11, 32'hFFFFFFAD);
    load(LBU, 32'h11, 32'h000000AD);
    load(LH,  32'h12, 32'hFFFFBEEF);
    load(LHU, 32'h12, 32'h0000BEEF);
    load(LB,  32'h13, 32'hFFFFFFEF);
    load(LB,  32'h10, 32'hFFFFFFDE);
    load(LHU, 32'h10, 32'h0000DEAD);

    // 4: misaligned word load
`ifdef LSU_MISALIGN_TRAP_EN
    start(LW, 32'h12, 32'h0);
    cyc(); Req = 1'b0;
    chk("mis_pulse", {31'b0, Misaligned}, 32'd1);
    chk("mis_rd", {31'b0, MemoryRead}, 32'd0);
    chk("mis_wr", {31'b0, MemoryWrite}, 32'd0);
    chk("mis_ready", {31'b0, Ready}, 32'd1);
    cyc();
    chk("mis_pulse_end", {31'b0, Misaligned}, 32'd0);
    chk("mis_rd2", {31'b0, MemoryRead}, 32'd0);
`else
    load(LW, 32'h12, 32'hDEADBEEF);
    load(LH, 32'h13, 32'hFFFFBEEF);
`endif

    // 5: reset during RD of a sub-word store
    start(SH, 32'h10, 32'h00005555);
    cyc(); Req = 1'b0;
    chk("rr_rd_en", {31'b0, MemoryRead}, 32'd1);
    Reset = 1'b1;
    #1;
    chk("rr_rd_drop", {31'b0, MemoryRead}, 32'd0);
    chk("rr_no_wr", {31'b0, MemoryWrite}, 32'd0);
    cyc(); cyc();
    Reset = 1'b0;
    cyc();
    chk("rr_no_wr2", {31'b0, MemoryWrite}, 32'd0);
    cyc();
    chk("rr_mem", mem[4], 32'hDEADBEEF);
    chk("rr_ready", {31'b0, Ready}, 32'd1);

    // 6: Req held across load completion and next store
    start(LW, 32'h10, 32'h0);
    cyc();
    chk("bb_rd", {31'b0, MemoryRead}, 32'd1);
    cyc();
    start(SW, 32'h14, 32'hCAFEF00D);
    chk("bb_resp_busy", {31'b0, Ready}, 32'd0);
    cyc();
    chk("bb_valid", {31'b0, LoadValid}, 32'd1);
    chk("bb_data", LoadData, 32'hDEADBEEF);
    chk("bb_ready", {31'b0, Ready}, 32'd1);
    chk("bb_idle_en", {30'b0, MemoryRead, MemoryWrite}, 32'd0);
    cyc(); Req = 1'b0;
    chk("bb_wr", {31'b0, MemoryWrite}, 32'd1);
    chk("bb_wr_nord", {31'b0, MemoryRead}, 32'd0);
    chk("bb_waddr", {26'b0, MemAddress}, 32'd5);
    chk("bb_valid_end", {31'b0, LoadValid}, 32'd0);
    cyc();
    chk("bb_mem", mem[5], 32'hCAFEF00D);
    chk("bb_mem4", mem[4], 32'hDEADBEEF);
    chk("bb_final_ready", {31'b0, Ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
